sgpr_wr_arbiter: RTL
====================

# sgpr_wr_arbiter

Combinational-grant, registered-state arbiter that drives `rfa_select_fu` into the SGPR write-port mux. It chooses one of ten write requesters each cycle: simd0-3, simf0-3, LSU and SALU. The SGPR commits masked writes with a one-cycle read-modify-write, so the arbiter inserts a bubble whenever a new write would hit the row being committed. It also gives the LSU priority, bounded by an anti-starvation counter, and counts conflict bubbles for performance monitoring.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants, while another requester is eligible and waiting, after which the LSU is masked for one cycle. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_req  in  10  write request per port: bits 0-3 simd0-3, bits 4-7 simf0-3, bit 8 LSU, bit 9 SALU
- wr_addr  in  90  flattened 9-bit SGPR dword address per port; port i uses bits [9i+8:9i]
- rfa_select_fu  out  16  one-hot grant, bit i = port i; bits 15:10 always 0
- grant_valid  out  1  OR of rfa_select_fu
- conflict_bubbles  out  16  saturating count of bubble cycles

## Operation
- **Row.** The row of an address is addr[8:2]. Conflict checks use row granularity, which is conservative for all widths: LSU 4 dwords, SALU and simx 2 dwords.
- **Registered state.**
  - last_valid: a grant occurred last cycle.
  - last_row: row of last cycle's granted address.
  - rr_ptr: 4-bit slot index. Slots 0-7 map to ports 0-7; slot 8 maps to port 9 (SALU).
  - starve_cnt: 4 bits.
  - conflict_bubbles.
- **Eligibility.** eligible[i] = wr_req[i] & ~(last_valid & row(wr_addr[i]) == last_row).
- **LSU priority.** lsu_ok = eligible[8] & (starve_cnt != STARVE_LIMIT). If lsu_ok, grant port 8.
- **Round robin.** Otherwise grant the first eligible slot in order rr_ptr+1, rr_ptr+2, … mod 9. Port 8 is never a round-robin slot. rr_ptr updates to the winning slot only on round-robin grants.
- **Starvation counter.**
  - LSU granted while any other port is eligible: starve_cnt += 1.
  - Any non-LSU grant, or no other port eligible: starve_cnt = 0.
  - At STARVE_LIMIT the LSU is masked for exactly one cycle. If no other port is eligible in that cycle, nothing is granted and starve_cnt clears.
- **Bubble.** If wr_req != 0 and no port is eligible, no grant is issued and conflict_bubbles increments, saturating at 0xFFFF. Idle cycles (wr_req == 0) are not counted.
- **Handshake.** A requester holds wr_req and wr_addr until it sees its bit in rfa_select_fu. The grant is combinational in the same cycle. Dropping a request before it is granted is legal and is simply not granted.
- **Grant constraint.** A grant is issued only for a port with wr_req high. At most one bit of rfa_select_fu is set.
- **last_row update.** last_valid <= grant_valid; last_row <= row of the granted port's address. With no grant, last_valid <= 0 and last_row holds.

## Timing
- **Reset values.** While rst is low:
  - rfa_select_fu = 0, grant_valid = 0 (forced, regardless of wr_req);
  - conflict_bubbles = 0, last_valid = 0, starve_cnt = 0, rr_ptr = 8, so simd0 is first in round robin.
- **Reset mid-operation.** Asserting rst aborts immediately and clears all state. A write in flight in the SGPR delay flop is unaffected.
- **Deassertion.** The first cycle after rst deasserts arbitrates with no conflict history.
- **Latency.**
  - Request to grant: 0 cycles.
  - A port conflicting with last cycle's row waits at least 1 cycle.
  - After granting row R, the same row is grantable again two cycles later, provided no grant of row R intervenes.
- **Consecutive grants.** Back-to-back grants to different rows are allowed every cycle.
- **Simultaneous events.**
  - If the LSU is ineligible by conflict, the round robin proceeds; this cycle is not an LSU grant, so it does not increment starve_cnt.
  - Saturation of conflict_bubbles does not affect arbitration.

## Test plan
- **Reset and round robin.** Reset, then wr_req = 0x0FF with distinct rows → grants in order ports 0,1,…,7. Then wr_req = 0x200 → grants port 9. rfa_select_fu is 0 throughout reset.
- **Round-robin wrap.** Ports 0, 3 and 9 hold requests with distinct rows, and each drops its request once granted → grants 0, 3, 9. Re-request all three → grants 0, 3, 9 again, wrapping from slot 8 to slot 0.
- **LSU priority and starvation, STARVE_LIMIT=4.** Ports 8 and 2 request continuously with distinct rows → port 8 granted 4 times, port 2 once, then the pattern repeats; starve_cnt observed 1,2,3,4,0.
- **Row conflict.** Cycle N: port 5 is granted at addr 0x10. Cycle N+1: port 6 requests addr 0x13 and is the only requester → no grant; conflict_bubbles goes 0 → 1. Cycle N+2: port 6 is granted.
- **Conflict skip.** Last grant at addr 0x40 (row 0x10). Port 8 requests 0x42 and port 1 requests 0x80 → port 1 is granted, port 8 the next cycle, with no bubble counted.
- **Mid-operation reset and saturation.** Preload conflict_bubbles to 0xFFFF via sustained conflict → it stays at 0xFFFF. Assert rst mid-stream → all outputs read 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sgpr_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sgpr_wr_if
//  Function : SGPR write-port request/grant bundle. Ten requesters each
//             present a request bit and a 9-bit dword address. The arbiter
//             returns a one-hot select plus a valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
interface sgpr_wr_if;
  logic [9:0]  wr_req;
  logic [89:0] wr_addr;
  logic [15:0] rfa_select_fu;
  logic        grant_valid;

  modport master (
    output wr_req,
    output wr_addr,
    input  rfa_select_fu,
    input  grant_valid
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    output rfa_select_fu,
    output grant_valid
  );
endinterface
`default_nettype wire

// File: rtl/sgpr_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sgpr_wr_arbiter
//  Function : Same-cycle grant arbiter for the SGPR write-port mux. The LSU
//             has priority, bounded by an anti-starvation counter. The other
//             nine ports are served round robin. A request whose row matches
//             last cycle's committed row is held off for one cycle so the
//             read-modify-write can finish. Conflict bubbles are counted.
//  Revision : 1.0 - initial release
// ============================================================================
module sgpr_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic  clk,
  input  wire logic  rst,
  sgpr_wr_if.slave   bus,
  output logic [15:0] conflict_bubbles
);

  localparam int         c_NPORTS   = 10;
  localparam int         c_LSU      = 8;
  localparam logic [3:0] c_LAST_SLT = 4'd8;  // slot 8 is the SALU (port 9)

  logic [6:0]  r_last_row;
  logic        r_last_valid;
  logic [3:0]  r_rr_ptr;
  logic [3:0]  r_starve_cnt;
  logic [15:0] r_conflict_bubbles;

  logic [6:0]  w_row [c_NPORTS];
  logic [9:0]  w_elig;
  logic [9:0]  w_unused_lsbs;
  logic [8:0]  w_slot_elig;
  logic        w_others_elig;
  logic        w_lsu_ok;
  logic        w_rr_found;
  logic [3:0]  w_rr_slot;
  logic [3:0]  w_rr_port;
  logic [15:0] w_grant;
  logic        w_grant_any;
  logic [6:0]  w_grant_row;
  logic        w_bubble;

  // Row extraction and conflict-based eligibility per port. The dword
  // offset within a row plays no part in conflict detection.
  for (genvar gi = 0; gi < c_NPORTS; gi++) begin : g_port
    assign w_row[gi]         = bus.wr_addr[9*gi+2 +: 7];
    assign w_elig[gi]        = bus.wr_req[gi] & ~(r_last_valid & (w_row[gi] == r_last_row));
    assign w_unused_lsbs[gi] = ^bus.wr_addr[9*gi +: 2];
  end

  assign w_slot_elig   = {w_elig[9], w_elig[7:0]};
  assign w_others_elig = |w_slot_elig;
  assign w_lsu_ok      = w_elig[c_LSU] && (r_starve_cnt != 4'(STARVE_LIMIT));
  assign w_bubble      = (|bus.wr_req) && !(|w_elig);

  // Round-robin search: first eligible slot after rr_ptr, modulo 9.
  always_comb begin
    logic [4:0] idx;
    w_rr_found = 1'b0;
    w_rr_slot  = r_rr_ptr;
    idx        = 5'd0;
    for (int k = 1; k <= 9; k++) begin
      idx = {1'b0, r_rr_ptr} + 5'(k);
      if (idx >= 5'd9) idx = idx - 5'd9;
      if (!w_rr_found && w_slot_elig[idx[3:0]]) begin
        w_rr_found = 1'b1;
        w_rr_slot  = idx[3:0];
      end
    end
  end

  assign w_rr_port = (w_rr_slot == c_LAST_SLT) ? 4'd9 : w_rr_slot;

  // One-hot grant and the row it commits; LSU wins whenever it is allowed.
  always_comb begin
    w_grant     = 16'h0000;
    w_grant_any = 1'b0;
    w_grant_row = w_row[w_rr_port];
    if (w_lsu_ok) begin
      w_grant[c_LSU] = 1'b1;
      w_grant_any    = 1'b1;
      w_grant_row    = w_row[c_LSU];
    end else if (w_rr_found) begin
      w_grant[w_rr_port] = 1'b1;
      w_grant_any        = 1'b1;
    end
  end

  // Reset forces the grant low combinationally so it drops before any edge.
  assign bus.rfa_select_fu = rst ? w_grant : 16'h0000;
  assign bus.grant_valid   = rst & w_grant_any;
  assign conflict_bubbles  = r_conflict_bubbles;

  // Conflict history, round-robin pointer, starvation and bubble counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_valid       <= 1'b0;
      r_last_row         <= 7'd0;
      r_rr_ptr           <= c_LAST_SLT;
      r_starve_cnt       <= 4'd0;
      r_conflict_bubbles <= 16'h0000;
    end else begin
      r_last_valid <= w_grant_any;
      if (w_grant_any) r_last_row <= w_grant_row;
      if (!w_lsu_ok && w_rr_found) r_rr_ptr <= w_rr_slot;
      r_starve_cnt <= (w_lsu_ok && w_others_elig) ? r_starve_cnt + 4'd1 : 4'd0;
      if (w_bubble && (r_conflict_bubbles != 16'hFFFF))
        r_conflict_bubbles <= r_conflict_bubbles + 16'd1;
    end
  end

endmodule
`default_nettype wire
